// File: rtl/adder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adder_pkg
// Description : Shared FSM state encoding and default operand width for the
//               bit-serial adder.
// Revision    : 1.0 - initial release
// ============================================================================
package adder_pkg;

  // Controller states for the serial adder
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Default operand/result width
  localparam int ADD_WIDTH_DEF = 8;

endpackage : adder_pkg
`default_nettype wire

// File: rtl/full_adder.sv
`default_nettype none
// ============================================================================
// Module      : full_adder
// Description : Single-bit full adder cell (sum and carry-out).
// Revision    : 1.0 - initial release
// ============================================================================
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);

  // Purely combinational sum/carry of three input bits
  assign sum   = a ^ b ^ cin;
  assign carry = (a & b) | (cin & (a ^ b));

endmodule : full_adder
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder
// Description : Bit-serial adder. Adds two WIDTH-bit unsigned operands plus a
//               carry-in, LSB first, one bit per clock through a single
//               full_adder cell. Result {cout,sum} is presented with a one
//               cycle done pulse and held until the next result completes.
//               Optional macro SERIAL_ADDER_OVF_EN adds a signed-overflow
//               output (ovf) captured together with sum/cout.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = ADD_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output logic             done
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int              CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_sr_q, a_sr_d;
  logic [WIDTH-1:0]   b_sr_q, b_sr_d;
  logic [WIDTH-1:0]   res_sr_q, res_sr_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
`ifdef SERIAL_ADDER_OVF_EN
  logic               ovf_q, ovf_d;
`endif

  logic               fa_sum;
  logic               fa_carry;
  logic [WIDTH-1:0]   res_shift;

  // The one and only arithmetic cell: current LSB pair plus the running carry
  full_adder u_fa (
    .a     (a_sr_q[0]),
    .b     (b_sr_q[0]),
    .cin   (carry_q),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  // Result register after this cycle's shift: new sum bit enters at the MSB,
  // so after WIDTH shifts the first (LSB) sum bit has reached bit 0
  assign res_shift = {fa_sum, {(WIDTH-1){1'b0}}} | (res_sr_q >> 1);

  // Next-state and datapath control; every target defaults to hold
  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    res_sr_d = res_sr_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        res_sr_d = res_shift;
        carry_d  = fa_carry;
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          state_d = ST_DONE;
          sum_d   = res_shift;
          cout_d  = fa_carry;
`ifdef SERIAL_ADDER_OVF_EN
          // carry into the MSB is the registered carry on the final bit
          ovf_d   = carry_q ^ fa_carry;
`endif
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset (reset wins over start)
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_sr_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      res_sr_q <= res_sr_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule : serial_adder
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_adder
// Description : Self-checking bench for serial_adder: directed vector table,
//               held-start, mid-operation reset and random operands checked
//               against an integer-arithmetic reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;
  logic             done;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Bench-side copy of the result the DUT should currently be holding
  logic [WIDTH-1:0] last_sum  = '0;
  logic             last_cout = 1'b0;

  typedef struct {
    logic [WIDTH-1:0] va;
    logic [WIDTH-1:0] vb;
    logic             vc;
    bit               keep;
    logic [WIDTH-1:0] exp_sum;
    logic             exp_cout;
    logic             exp_ovf;
  } vec_t;

  vec_t vecs[7];

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .sum   (sum),
    .cout  (cout),
    .busy  (busy),
    .done  (done)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One full operation: start pulse (or held start), per-cycle busy/done
  // and hold checks, then result compare against the supplied expectation
  task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tbv,
                        input logic tc, input bit keep,
                        input logic [WIDTH-1:0] es, input logic ec, input logic eo);
    int bad;
    @(negedge clk);
    a = ta; b = tbv; cin = tc; start = 1'b1;
    bad = 0;
    for (int k = 1; k <= WIDTH + 1; k++) begin
      @(negedge clk);
      if (!keep) start = 1'b0;
      else begin
        a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
      end
      if (busy !== (k <= WIDTH)) bad++;
      if (done !== (k == WIDTH + 1)) bad++;
      if (k <= WIDTH && (sum !== last_sum || cout !== last_cout)) bad++;
    end
    chk("handshake_timing", 32'(bad), 32'd0);
    chk("sum", 32'(sum), 32'(es));
    chk("cout", 32'(cout), 32'(ec));
`ifdef SERIAL_ADDER_OVF_EN
    chk("ovf", 32'(ovf), 32'(eo));
`else
    if (eo === 1'bx) $display("note: unknown ovf expectation");
`endif
    last_sum  = es;
    last_cout = ec;
    if (keep) begin
      @(negedge clk);
      chk("idle_after_done", {30'd0, busy, done}, 32'd0);
      chk("sum_held_after_done", 32'(sum), 32'(es));
      start = 1'b0;
    end
  endtask

  initial begin
    int bad;
    int s_signed;
    logic [WIDTH:0] ref_v;
    logic [WIDTH-1:0] ra, rb;
    logic rc, ro;

    // a, b, cin, keep_start, expected sum, cout, signed overflow
    vecs[0] = '{8'h35, 8'h4A, 1'b0, 1'b0, 8'h7F, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0};
    vecs[3] = '{8'h10, 8'h20, 1'b0, 1'b1, 8'h30, 1'b0, 1'b0};
    vecs[4] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[5] = '{8'h80, 8'hFF, 1'b0, 1'b0, 8'h7F, 1'b1, 1'b1};
    vecs[6] = '{8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0};

    rst = 1'b1; start = 1'b1; a = '1; b = '1; cin = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {22'd0, sum, cout, busy, done}, 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
    chk("reset_ovf", 32'(ovf), 32'd0);
`endif
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Directed table, applied back to back
    for (int i = 0; i < 7; i++)
      run_op(vecs[i].va, vecs[i].vb, vecs[i].vc, vecs[i].keep,
             vecs[i].exp_sum, vecs[i].exp_cout, vecs[i].exp_ovf);

    // Reset in the fourth busy cycle aborts the operation silently
    @(negedge clk);
    a = 8'h5A; b = 8'h33; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_state", {22'd0, sum, cout, busy, done}, 32'd0);
    rst = 1'b0;
    bad = 0;
    repeat (WIDTH + 2) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0) bad++;
    end
    chk("no_done_after_abort", 32'(bad), 32'd0);
    last_sum = '0; last_cout = 1'b0;
    run_op(8'h5A, 8'h33, 1'b1, 1'b0, 8'h8E, 1'b0, 1'b1);

    // Random operands against plain integer arithmetic
    for (int i = 0; i < 20; i++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      rc = 1'($urandom);
      ref_v = {1'b0, ra} + {1'b0, rb} + {{WIDTH{1'b0}}, rc};
      s_signed = int'($signed(ra)) + int'($signed(rb)) + int'(rc);
      ro = (s_signed > 127) || (s_signed < -128);
      run_op(ra, rb, rc, 1'b0, ref_v[WIDTH-1:0], ref_v[WIDTH], ro);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_serial_adder
`default_nettype wire

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial adder: one `full_adder` cell, a carry flip-flop and operand/result shift registers.
- Adds two WIDTH-bit operands, LSB first, one bit per clock.
- Sits directly around the existing 1-bit `full_adder`: feeds it one operand bit pair plus the registered carry each cycle, and consumes its sum/carry outputs.
- Area-minimal alternative to a ripple-carry adder for the arithmetic examples.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 2..32).
- CNT_W, $clog2(WIDTH+1), bit-count register width (localparam, derived; not overridable).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request: sample operands and begin addition
- a  input  WIDTH  operand A, sampled only when start is accepted
- b  input  WIDTH  operand B, sampled only when start is accepted
- cin  input  1  carry-in, sampled only when start is accepted
- sum  output  WIDTH  result, valid when done=1, held until next accepted start
- cout  output  1  final carry-out, same validity as sum
- busy  output  1  high while addition is in progress
- done  output  1  single-cycle pulse marking result valid

Behaviour:
- One clock `clk`; reset `rst` is synchronous and active-high. All state updates on the rising edge of clk.
- Reset values:
  - state=IDLE; sum=0, cout=0, busy=0, done=0.
  - Operand shift registers=0, carry reg=0, bit count=0.
  - ovf=0 when the optional feature is compiled in.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If start=1 at an edge: load a_sr<=a, b_sr<=b, carry<=cin, cnt<=0; go to RUN.
  - Otherwise stay in IDLE.
- RUN, each edge:
  - The full_adder sees a_sr[0], b_sr[0], carry.
  - res_sr <= {fa_sum, res_sr[WIDTH-1:1]} (shift right; sum bit enters at the MSB).
  - carry <= fa_carry.
  - a_sr and b_sr shift right by 1, zero-fill.
  - cnt <= cnt+1.
  - When cnt==WIDTH-1 at the edge: go to DONE, load sum <= final res_sr value and cout <= fa_carry.
- DONE: done=1 for exactly one cycle, then unconditionally to IDLE.
- busy=1 in RUN only. done=1 in DONE only.
- Latency: start sampled at edge 0 -> busy high for cycles 1..WIDTH -> done high in cycle WIDTH+1. One new operation at most every WIDTH+2 cycles.
- start while state≠IDLE (RUN or DONE) is ignored; no queuing.
- sum/cout keep the previous result through IDLE and through the next RUN. They update only on the RUN->DONE transition.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1). Operands are treated as unsigned.
- rst asserted mid-operation: abort at the next edge and return to all reset values. No done pulse for the aborted operation.
- rst and start high on the same edge: rst wins.

Optional Feature:
- Macro: SERIAL_ADDER_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit): signed two's-complement overflow.
  - ovf = carry into MSB XOR carry out of MSB, captured at the RUN->DONE transition together with sum/cout.
  - Held with sum; reset to 0.
- Not defined: no ovf port, no extra register; remaining behaviour identical.

Decomposition:
- Package `adder_pkg`:
  - FSM state enum/localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - Default width constant ADD_WIDTH_DEF=8.
- Sub-module: instantiate the existing `full_adder` (ports a, b, cin, sum, carry) as the single per-bit cell; no other hierarchy.

Test Plan:
- a=8'h35, b=8'h4A, cin=0, start pulse -> busy high 8 cycles; done in cycle 9; sum=8'h7F, cout=0.
- a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
- Start accepted with a=8'h10, b=8'h20. Hold start=1 and change a/b during RUN and DONE -> single done pulse, sum=8'h30; next op begins only after returning to IDLE.
- Start an operation, assert rst in cycle 4 -> next edge: busy=0, sum=0, cout=0; no done pulse; a fresh start afterwards gives the correct result.
- Back-to-back: start re-asserted the cycle after done -> second result correct; previous sum held until the second done.
- With SERIAL_ADDER_OVF_EN: a=8'h7F, b=8'h01 -> sum=8'h80, ovf=1. Then a=8'h80, b=8'hFF -> sum=8'h7F, cout=1, ovf=1. Then a=8'h01, b=8'h01 -> ovf=0.
